tcam_match_array: RTL and testbench

//   16-entry ternary CAM storage and compare array, directly upstream of the
//   16-to-4 priority encoder. Holds {key, mask, valid} per entry, accepts

---
 rtl/tcam_match_array_pkg.sv | 16 +
 rtl/tcam_match_array_entry.sv | 37 +++
 rtl/tcam_match_array.sv | 60 ++++++
 tb/tb_tcam_match_array.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_match_array_pkg.sv
// Shared sizing and the ternary compare rule for the 16-entry TCAM match array.
package tcam_match_array_pkg;

  localparam int ENTRIES = 16;
  localparam int KEY_W   = 8;
  localparam int ADDR_W  = 4;

  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [ENTRIES-1:0] lines_t;

  // A mask bit of 1 makes that key bit a don't-care.
  function automatic logic tcam_bits_match(input key_t stored, input key_t mask, input key_t k);
    return ((stored ^ k) & ~mask) == '0;
  endfunction

endpackage

// File: rtl/tcam_match_array_entry.sv
// One TCAM entry: key/mask/valid storage and a combinational match against the staged key.
module tcam_match_array_entry
  import tcam_match_array_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic we,
  input  key_t wr_key,
  input  key_t wr_mask,
  input  logic wr_vld,
  input  key_t srch_key,
  output logic match
);

  key_t key_q;
  key_t mask_q;
  logic vld_q;

  // clr wins over a write in the same cycle; key/mask survive a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      mask_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr) begin
      vld_q  <= 1'b0;
    end else if (we) begin
      key_q  <= wr_key;
      mask_q <= wr_mask;
      vld_q  <= wr_vld;
    end
  end

  assign match = vld_q && tcam_bits_match(key_q, mask_q, srch_key);

endmodule

// File: rtl/tcam_match_array.sv
// 16-entry TCAM compare array: 2-cycle pipeline (key stage, registered match vector).
// Handshake: srch_req is a fire-and-forget valid with no ready; one search per cycle is
// always accepted and produces exactly one match_vld pulse two cycles later unless rst intervenes.
module tcam_match_array
  import tcam_match_array_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [KEY_W-1:0]  wr_mask,
  input  logic              wr_vld,
  input  logic              clr_all,
  input  logic              srch_req,
  input  logic [KEY_W-1:0]  srch_key,
  output logic              match_vld,
  output logic [ENTRIES-1:0] match_lines,
  output logic              hit,
  output logic              busy
);

  logic   s1_vld;
  key_t   s1_key;
  lines_t cmp;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    tcam_match_array_entry u_entry (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_all),
      .we       (wr_en && (wr_addr == ADDR_W'(gi))),
      .wr_key   (wr_key),
      .wr_mask  (wr_mask),
      .wr_vld   (wr_vld),
      .srch_key (s1_key),
      .match    (cmp[gi])
    );
  end

  // Compare happens in the S1 cycle against the array as it stands then, so a
  // write or clear landing on the edge before S1 is already visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s1_key      <= '0;
      match_vld   <= 1'b0;
      match_lines <= '0;
    end else begin
      s1_vld    <= srch_req;
      match_vld <= s1_vld;
      if (srch_req) s1_key <= srch_key;
      if (s1_vld) match_lines <= cmp;
    end
  end

  assign busy = s1_vld;
  assign hit  = match_vld & (|match_lines);

endmodule

// File: tb/tb_tcam_match_array.sv
// Directed-vector bench for tcam_match_array: pipeline timing, ternary match, write/clear ordering, reset.
module tb_tcam_match_array;
  import tcam_match_array_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [KEY_W-1:0]  wr_key;
  logic [KEY_W-1:0]  wr_mask;
  logic              wr_vld;
  logic              clr_all;
  logic              srch_req;
  logic [KEY_W-1:0]  srch_key;
  logic              match_vld;
  logic [ENTRIES-1:0] match_lines;
  logic              hit;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  tcam_match_array dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_key      (wr_key),
    .wr_mask     (wr_mask),
    .wr_vld      (wr_vld),
    .clr_all     (clr_all),
    .srch_req    (srch_req),
    .srch_key    (srch_key),
    .match_vld   (match_vld),
    .match_lines (match_lines),
    .hit         (hit),
    .busy        (busy)
  );

  // driver tasks; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_key = '0; wr_mask = '0; wr_vld = 0;
    clr_all = 0; srch_req = 0; srch_key = '0;
  endtask

  task automatic write_entry(input logic [ADDR_W-1:0] a, input logic [KEY_W-1:0] k,
                             input logic [KEY_W-1:0] m, input logic v);
    wr_en = 1; wr_addr = a; wr_key = k; wr_mask = m; wr_vld = v;
    tick();
    wr_en = 0;
  endtask

  // Issue one search, return what the output stage shows two cycles later.
  task automatic run_search(input logic [KEY_W-1:0] k, output logic vld,
                            output logic [ENTRIES-1:0] lines, output logic h);
    srch_req = 1; srch_key = k;
    tick();
    srch_req = 0;
    tick();
    vld = match_vld; lines = match_lines; h = hit;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    n_cmp++;
    if ({match_vld, match_lines, hit, busy} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b lines=%h hit=%b busy=%b, need all 0",
               match_vld, match_lines, hit, busy);
    end
  endtask

  task automatic test_empty_search();
    logic v, h;
    logic [ENTRIES-1:0] l;
    srch_req = 1; srch_key = 8'h5A;
    tick();
    srch_req = 0;
    n_cmp++;
    if (busy !== 1'b1 || match_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_s1: got busy=%b vld=%b, need busy=1 vld=0", busy, match_vld);
    end
    tick();
    v = match_vld; l = match_lines; h = hit;
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0000 || h !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_search: got vld=%b lines=%h hit=%b, need 1/0000/0", v, l, h);
    end
  endtask

  task automatic test_basic_match();
    logic v, h;
    logic [ENTRIES-1:0] l;
    write_entry(4'd3, 8'h5A, 8'h00, 1'b1);
    write_entry(4'd9, 8'h50, 8'h0F, 1'b1);
    run_search(8'h5A, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0208 || h !== 1'b1) begin
      n_fail++;
      $display("FAIL match_5a: got vld=%b lines=%h hit=%b, need 1/0208/1", v, l, h);
    end
    tick();
    n_cmp++;
    if (match_vld !== 1'b0 || hit !== 1'b0 || match_lines !== 16'h0208 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_after_pulse: got vld=%b hit=%b lines=%h busy=%b, need 0/0/0208/0",
               match_vld, hit, match_lines, busy);
    end
    run_search(8'h5B, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0200 || h !== 1'b1) begin
      n_fail++;
      $display("FAIL match_5b: got vld=%b lines=%h hit=%b, need 1/0200/1", v, l, h);
    end
    run_search(8'h60, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0000 || h !== 1'b0) begin
      n_fail++;
      $display("FAIL match_60: got vld=%b lines=%h hit=%b, need 1/0000/0", v, l, h);
    end
  endtask

  task automatic test_top_entry();
    logic v, h;
    logic [ENTRIES-1:0] l;
    write_entry(4'd15, 8'hA0, 8'h0F, 1'b1);
    run_search(8'hAB, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h8000 || h !== 1'b1) begin
      n_fail++;
      $display("FAIL entry15: got vld=%b lines=%h hit=%b, need 1/8000/1", v, l, h);
    end
    run_search(8'hB0, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0000) begin
      n_fail++;
      $display("FAIL entry15_miss: got vld=%b lines=%h, need 1/0000", v, l);
    end
  endtask

  task automatic test_back_to_back();
    logic [KEY_W-1:0]   keys [3];
    logic [ENTRIES-1:0] exp  [3];
    keys = '{8'h5A, 8'h5B, 8'h60};
    exp  = '{16'h0208, 16'h0200, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      srch_req = 1; srch_key = keys[i];
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (match_vld !== 1'b1 || match_lines !== exp[i-1]) begin
          n_fail++;
          $display("FAIL b2b_%0d: got vld=%b lines=%h, need 1/%h", i - 1, match_vld, match_lines, exp[i-1]);
        end
      end
    end
    srch_req = 0;
    tick();
    n_cmp++;
    if (match_vld !== 1'b1 || match_lines !== exp[2]) begin
      n_fail++;
      $display("FAIL b2b_2: got vld=%b lines=%h, need 1/%h", match_vld, match_lines, exp[2]);
    end
    tick();
    n_cmp++;
    if (match_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got vld=%b busy=%b, need 0/0", match_vld, busy);
    end
  endtask

  task automatic test_write_timing();
    logic v, h;
    logic [ENTRIES-1:0] l;
    // write in the request cycle is seen by the compare
    srch_req = 1; srch_key = 8'h5A;
    wr_en = 1; wr_addr = 4'd3; wr_key = 8'h5A; wr_mask = 8'h00; wr_vld = 0;
    tick();
    srch_req = 0; wr_en = 0;
    tick();
    n_cmp++;
    if (match_vld !== 1'b1 || match_lines !== 16'h0200) begin
      n_fail++;
      $display("FAIL write_same_req: got vld=%b lines=%h, need 1/0200", match_vld, match_lines);
    end
    write_entry(4'd3, 8'h5A, 8'h00, 1'b1);
    // write during the compare cycle is not seen by it
    srch_req = 1; srch_key = 8'h5A;
    tick();
    srch_req = 0;
    wr_en = 1; wr_addr = 4'd3; wr_key = 8'h5A; wr_mask = 8'h00; wr_vld = 0;
    tick();
    wr_en = 0;
    n_cmp++;
    if (match_vld !== 1'b1 || match_lines !== 16'h0208) begin
      n_fail++;
      $display("FAIL write_in_s1: got vld=%b lines=%h, need 1/0208", match_vld, match_lines);
    end
    run_search(8'h5A, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0200) begin
      n_fail++;
      $display("FAIL write_after: got vld=%b lines=%h, need 1/0200", v, l);
    end
    write_entry(4'd3, 8'h5A, 8'h00, 1'b1);
  endtask

  task automatic test_clr_all();
    logic v, h;
    logic [ENTRIES-1:0] l;
    clr_all = 1;
    wr_en = 1; wr_addr = 4'd5; wr_key = 8'hFF; wr_mask = 8'hFF; wr_vld = 1;
    tick();
    clr_all = 0; wr_en = 0;
    run_search(8'h5A, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0000 || h !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_5a: got vld=%b lines=%h hit=%b, need 1/0000/0", v, l, h);
    end
    run_search(8'h33, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0000) begin
      n_fail++;
      $display("FAIL clr_33: got vld=%b lines=%h, need 1/0000", v, l);
    end
    write_entry(4'd5, 8'hFF, 8'hFF, 1'b1);
    run_search(8'h33, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0020 || h !== 1'b1) begin
      n_fail++;
      $display("FAIL wildcard_e5: got vld=%b lines=%h hit=%b, need 1/0020/1", v, l, h);
    end
  endtask

  task automatic test_rst_mid_search();
    logic v, h;
    logic [ENTRIES-1:0] l;
    write_entry(4'd3, 8'h5A, 8'h00, 1'b1);
    srch_req = 1; srch_key = 8'h5A;
    tick();
    srch_req = 0;
    rst = 1;
    tick();
    rst = 0;
    n_cmp++;
    if (match_vld !== 1'b0 || match_lines !== 16'h0000 || busy !== 1'b0 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got vld=%b lines=%h busy=%b hit=%b, need all 0",
               match_vld, match_lines, busy, hit);
    end
    tick();
    n_cmp++;
    if (match_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_pulse: got vld=%b, need 0", match_vld);
    end
    run_search(8'h5A, v, l, h);
    n_cmp++;
    if (v !== 1'b1 || l !== 16'h0000 || h !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cleared: got vld=%b lines=%h hit=%b, need 1/0000/0", v, l, h);
    end
  endtask

  initial begin
    test_reset();
    test_empty_search();
    test_basic_match();
    test_top_entry();
    test_back_to_back();
    test_write_timing();
    test_clr_all();
    test_rst_mid_search();
    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
